// File: rtl/rf_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_pkg
// Purpose  : Shared types and constants for the register-file write-back
//            arbiter (rf_wb_arbiter) and its load buffer (rf_wb_ld_fifo).
// Contents : XLEN_DEFAULT - default data width
//            REG_ADDR_W   - register address width
//            wb_req_t     - {rd, data} write-back request
//            wb_src_e     - source selected for the write port
// Revision : 1.0 - initial release
// ============================================================================
package rf_wb_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int REG_ADDR_W   = 5;

   typedef struct packed {
      logic [REG_ADDR_W-1:0]   rd;
      logic [XLEN_DEFAULT-1:0] data;
   } wb_req_t;

   typedef enum logic [1:0] {
      WB_SRC_NONE = 2'd0,
      WB_SRC_ALU  = 2'd1,
      WB_SRC_LD   = 2'd2
   } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/rf_wb_ld_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_ld_fifo
// Purpose  : DEPTH-entry strict FIFO of load write-back requests. Pointers
//            carry one extra MSB so full/empty need no separate counter.
//            Status flags come from registered pointers only, so an entry
//            pushed this cycle is never visible at the head the same cycle.
// Ports    : i_clk, i_reset_n (async active-low)
//            i_push, i_push_data  - enqueue (caller guarantees !o_full)
//            i_pop                - dequeue (caller guarantees !o_empty)
//            o_full, o_empty      - status
//            o_head               - oldest entry
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_ld_fifo
   import rf_wb_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = wb_req_t
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_push,
   input  T     i_push_data,
   input  logic i_pop,
   output logic o_full,
   output logic o_empty,
   output T     o_head
);

   localparam int                 c_ptr_w   = $clog2(DEPTH);
   localparam logic [c_ptr_w:0]   c_ptr_one = {{c_ptr_w{1'b0}}, 1'b1};

   logic [c_ptr_w:0] r_wr_ptr;
   logic [c_ptr_w:0] r_rd_ptr;
   T                 r_mem [DEPTH];

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
   end

   // Storage needs no reset: entries are only observed behind a valid pointer.
   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wr_ptr[c_ptr_w-1:0]] <= i_push_data;
   end

   // Same index with differing wrap bits means the writer has lapped the reader.
   assign o_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                    (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_head  = r_mem[r_rd_ptr[c_ptr_w-1:0]];

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Sole driver of the integer register file write port. Merges
//            single-cycle ALU results with buffered load responses, keeps a
//            pending-load scoreboard for decode RAW stalls, and bounds load
//            starvation by stalling the ALU for one cycle.
// Ports    : i_clk, i_reset_n                 - clock, async active-low reset
//            i_alu_wren/rd/data, o_alu_stall   - ALU producer
//            i_ld_valid/rd/data, o_ld_ready    - load response handshake
//            i_ld_issue, i_ld_issue_rd         - load issue (scoreboard set)
//            i_rs1_addr/i_rs2_addr, o_rsN_busy - decode hazard query
//            o_rd_addr/o_rd_data/o_rd_wren     - register file write port
// Options  : RF_WB_FWD_EN - adds i_rsN_rdata inputs and o_rsN_fwd outputs
//            that bypass the value currently on the write port.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
   import rf_wb_pkg::*;
#(
   parameter int XLEN         = XLEN_DEFAULT,
   parameter int LD_DEPTH     = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_alu_wren,
   input  logic [REG_ADDR_W-1:0] i_alu_rd,
   input  logic [XLEN-1:0]       i_alu_data,
   output logic                  o_alu_stall,
   input  logic                  i_ld_valid,
   output logic                  o_ld_ready,
   input  logic [REG_ADDR_W-1:0] i_ld_rd,
   input  logic [XLEN-1:0]       i_ld_data,
   input  logic                  i_ld_issue,
   input  logic [REG_ADDR_W-1:0] i_ld_issue_rd,
   input  logic [REG_ADDR_W-1:0] i_rs1_addr,
   input  logic [REG_ADDR_W-1:0] i_rs2_addr,
`ifdef RF_WB_FWD_EN
   input  logic [XLEN-1:0]       i_rs1_rdata,
   input  logic [XLEN-1:0]       i_rs2_rdata,
   output logic [XLEN-1:0]       o_rs1_fwd,
   output logic [XLEN-1:0]       o_rs2_fwd,
`endif
   output logic                  o_rs1_busy,
   output logic                  o_rs2_busy,
   output logic [REG_ADDR_W-1:0] o_rd_addr,
   output logic [XLEN-1:0]       o_rd_data,
   output logic                  o_rd_wren
);

   // Same shape as wb_req_t but sized by this instance's XLEN.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } ld_req_t;

   localparam int                 c_cnt_w      = $clog2(STARVE_LIMIT + 1);
   localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_LIMIT);
   localparam logic [c_cnt_w-1:0] c_cnt_one    = {{(c_cnt_w-1){1'b0}}, 1'b1};

   logic                  r_rd_wren;
   logic [REG_ADDR_W-1:0] r_rd_addr;
   logic [XLEN-1:0]       r_rd_data;
   logic [c_cnt_w-1:0]    r_starve_cnt;
   logic                  r_alu_stall;
   logic [31:0]           r_sb;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   ld_req_t               w_push_req;
   ld_req_t               w_head;
   wb_src_e               w_src;
   logic [c_cnt_w-1:0]    w_cnt_nxt;
   logic [31:0]           w_sb_nxt;

   // ------------------------------------------------------------------------
   // Load buffer. Ready depends only on registered occupancy, so a pop in a
   // full cycle does not open a slot until the following cycle.
   // ------------------------------------------------------------------------
   assign o_ld_ready = !w_full;
   assign w_push     = i_ld_valid && !w_full;
   assign w_push_req = {i_ld_rd, i_ld_data};

   rf_wb_ld_fifo #(
      .DEPTH (LD_DEPTH),
      .T     (ld_req_t)
   ) u_ld_fifo (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_push      (w_push),
      .i_push_data (w_push_req),
      .i_pop       (w_pop),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_head      (w_head)
   );

   // ------------------------------------------------------------------------
   // Arbitration: an ALU write to x0 is not a win, so the buffer may use
   // that cycle.
   // ------------------------------------------------------------------------
   always_comb begin
      w_src = WB_SRC_NONE;
      if (i_alu_wren && !r_alu_stall && (i_alu_rd != '0)) begin
         w_src = WB_SRC_ALU;
      end else if (!w_empty) begin
         w_src = WB_SRC_LD;
      end
   end

   assign w_pop = (w_src == WB_SRC_LD);

   // Starvation: counts ALU wins over a waiting load; the stall it raises
   // forces a pop, which in turn clears the count, so the stall lasts one cycle.
   always_comb begin
      w_cnt_nxt = r_starve_cnt;
      if (w_pop) begin
         w_cnt_nxt = '0;
      end else if ((w_src == WB_SRC_ALU) && !w_empty) begin
         w_cnt_nxt = r_starve_cnt + c_cnt_one;
      end
   end

   // Scoreboard: clear is applied before set so a same-cycle issue wins.
   always_comb begin
      w_sb_nxt = r_sb;
      if (w_pop) begin
         w_sb_nxt[w_head.rd] = 1'b0;
      end
      if (i_ld_issue && (i_ld_issue_rd != '0)) begin
         w_sb_nxt[i_ld_issue_rd] = 1'b1;
      end
      w_sb_nxt[0] = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_rd_wren    <= 1'b0;
         r_rd_addr    <= '0;
         r_rd_data    <= '0;
         r_starve_cnt <= '0;
         r_alu_stall  <= 1'b0;
         r_sb         <= '0;
      end else begin
         r_starve_cnt <= w_cnt_nxt;
         r_alu_stall  <= (w_cnt_nxt == c_starve_max);
         r_sb         <= w_sb_nxt;
         case (w_src)
            WB_SRC_ALU: begin
               r_rd_wren <= 1'b1;
               r_rd_addr <= i_alu_rd;
               r_rd_data <= i_alu_data;
            end
            WB_SRC_LD: begin
               // A load to x0 is consumed but never written.
               r_rd_wren <= (w_head.rd != '0);
               r_rd_addr <= w_head.rd;
               r_rd_data <= w_head.data;
            end
            default: begin
               r_rd_wren <= 1'b0;
            end
         endcase
      end
   end

   assign o_rd_wren   = r_rd_wren;
   assign o_rd_addr   = r_rd_addr;
   assign o_rd_data   = r_rd_data;
   assign o_alu_stall = r_alu_stall;
   assign o_rs1_busy  = r_sb[i_rs1_addr];
   assign o_rs2_busy  = r_sb[i_rs2_addr];

`ifdef RF_WB_FWD_EN
   assign o_rs1_fwd = (r_rd_wren && (r_rd_addr == i_rs1_addr) && (i_rs1_addr != '0)) ?
                      r_rd_data : i_rs1_rdata;
   assign o_rs2_fwd = (r_rd_wren && (r_rd_addr == i_rs2_addr) && (i_rs2_addr != '0)) ?
                      r_rd_data : i_rs2_rdata;
`endif

`ifndef SYNTHESIS
   // The ALU must never overwrite a register that a load still owns.
   a_no_alu_raw: assert property (@(posedge i_clk) disable iff (!i_reset_n)
      !(i_alu_wren && (i_alu_rd != '0) && r_sb[i_alu_rd]));
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Purpose  : Self-checking bench for rf_wb_arbiter: directed scenarios then
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

   localparam int XLEN         = 32;
   localparam int LD_DEPTH     = 2;
   localparam int STARVE_LIMIT = 4;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ld_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        alu_wren;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_stall;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        ld_issue;
   logic [4:0]  ld_issue_rd;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic        rs1_busy;
   logic        rs2_busy;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        rd_wren;
`ifdef RF_WB_FWD_EN
   logic [31:0] rs1_rdata;
   logic [31:0] rs2_rdata;
   logic [31:0] rs1_fwd;
   logic [31:0] rs2_fwd;
`endif

   // Reference model state
   ld_t         m_q[$];
   logic [31:0] m_sb;
   int          m_starve;
   logic        m_stall;
   logic        m_wren;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic        m_accepted;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   rf_wb_arbiter #(
      .XLEN         (XLEN),
      .LD_DEPTH     (LD_DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .i_clk         (clk),
      .i_reset_n     (reset_n),
      .i_alu_wren    (alu_wren),
      .i_alu_rd      (alu_rd),
      .i_alu_data    (alu_data),
      .o_alu_stall   (alu_stall),
      .i_ld_valid    (ld_valid),
      .o_ld_ready    (ld_ready),
      .i_ld_rd       (ld_rd),
      .i_ld_data     (ld_data),
      .i_ld_issue    (ld_issue),
      .i_ld_issue_rd (ld_issue_rd),
      .i_rs1_addr    (rs1_addr),
      .i_rs2_addr    (rs2_addr),
`ifdef RF_WB_FWD_EN
      .i_rs1_rdata   (rs1_rdata),
      .i_rs2_rdata   (rs2_rdata),
      .o_rs1_fwd     (rs1_fwd),
      .o_rs2_fwd     (rs2_fwd),
`endif
      .o_rs1_busy    (rs1_busy),
      .o_rs2_busy    (rs2_busy),
      .o_rd_addr     (rd_addr),
      .o_rd_data     (rd_data),
      .o_rd_wren     (rd_wren)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      alu_wren = 1'b0; alu_rd = '0; alu_data = '0;
      ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
      ld_issue = 1'b0; ld_issue_rd = '0;
      rs1_addr = '0; rs2_addr = '0;
`ifdef RF_WB_FWD_EN
      rs1_rdata = '0; rs2_rdata = '0;
`endif
   endtask

   task automatic model_reset();
      m_q.delete();
      m_sb = '0; m_starve = 0; m_stall = 1'b0;
      m_wren = 1'b0; m_addr = '0; m_data = '0; m_accepted = 1'b0;
   endtask

   // One clock of the write-back rules applied to the currently driven inputs.
   task automatic model_advance();
      bit  alu_win, pop, acc;
      int  occ;
      ld_t head;
      occ     = m_q.size();
      alu_win = alu_wren && (alu_rd != 0) && !m_stall;
      pop     = !alu_win && (occ > 0);
      acc     = ld_valid && (occ < LD_DEPTH);
      if (alu_win) begin
         m_wren = 1'b1; m_addr = alu_rd; m_data = alu_data;
      end else if (pop) begin
         head   = m_q.pop_front();
         m_wren = (head.rd != 0); m_addr = head.rd; m_data = head.data;
         m_sb[head.rd] = 1'b0;
      end else begin
         m_wren = 1'b0;
      end
      if (pop) m_starve = 0;
      else if (alu_win && occ > 0) m_starve++;
      m_stall = (m_starve == STARVE_LIMIT);
      if (ld_issue && ld_issue_rd != 0) m_sb[ld_issue_rd] = 1'b1;
      m_sb[0] = 1'b0;
      if (acc) m_q.push_back('{rd: ld_rd, data: ld_data});
      m_accepted = acc;
   endtask

   // Called at a negedge with inputs set: check, advance model, next negedge.
   task automatic step();
      #2;
      chk("ld_ready", {31'd0, ld_ready}, {31'd0, m_q.size() < LD_DEPTH});
      chk("alu_stall", {31'd0, alu_stall}, {31'd0, m_stall});
      chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, m_sb[rs1_addr]});
      chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, m_sb[rs2_addr]});
      chk("rd_wren", {31'd0, rd_wren}, {31'd0, m_wren});
      if (m_wren) begin
         chk("rd_addr", {27'd0, rd_addr}, {27'd0, m_addr});
         chk("rd_data", rd_data, m_data);
      end
`ifdef RF_WB_FWD_EN
      chk("rs1_fwd", rs1_fwd, (m_wren && m_addr == rs1_addr && rs1_addr != 0) ? m_data : rs1_rdata);
      chk("rs2_fwd", rs2_fwd, (m_wren && m_addr == rs2_addr && rs2_addr != 0) ? m_data : rs2_rdata);
`endif
      model_advance();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [4:0] r;
      logic [4:0] pend[$];

      // ---------------- reset state ----------------
      idle_inputs();
      reset_n = 1'b0;
      model_reset();
      #2;
      chk("rst_wren", {31'd0, rd_wren}, 32'd0);
      chk("rst_addr", {27'd0, rd_addr}, 32'd0);
      chk("rst_data", rd_data, 32'd0);
      chk("rst_ready", {31'd0, ld_ready}, 32'd1);
      chk("rst_stall", {31'd0, alu_stall}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // ---------------- ALU write ----------------
      alu_wren = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      step();
      idle_inputs();
      step();
      chk("alu_wr_addr", {27'd0, rd_addr}, 32'd5);

      // ---------------- load RAW tracking, rd=7 ----------------
      ld_issue = 1'b1; ld_issue_rd = 5'd7;
      step();
      idle_inputs(); rs1_addr = 5'd7;
      step();
      ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234;
      step();
      ld_valid = 1'b0;
      step();                       // pop cycle, busy still set
      step();                       // write visible, busy clear
      chk("ld7_data", rd_data, 32'h1234);
      step();

      // ---------------- starvation with full buffer ----------------
      idle_inputs();
      alu_wren = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0A0_0001;
      ld_valid = 1'b1; ld_rd = 5'd11; ld_data = 32'h1111;
      step();
      ld_rd = 5'd12; ld_data = 32'h2222;
      step();
      ld_valid = 1'b0;
      for (int i = 0; i < 14; i++) begin
         alu_data = 32'hA0A0_0000 + i;
         step();
      end
      idle_inputs();
      step();

      // ---------------- x0 writes ----------------
      alu_wren = 1'b1; alu_rd = 5'd0; alu_data = 32'hBAD0;
      ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hBAD1;
      step();
      idle_inputs();
      step();
      step();
      chk("x0_ready", {31'd0, ld_ready}, 32'd1);

      // ---------------- same-cycle issue and pop of rd=3 ----------------
      ld_issue = 1'b1; ld_issue_rd = 5'd3;
      step();
      idle_inputs();
      ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h3333;
      step();
      ld_valid = 1'b0; ld_issue = 1'b1; ld_issue_rd = 5'd3; rs2_addr = 5'd3;
      step();
      ld_issue = 1'b0;
      step();
      chk("sb3_kept", {31'd0, rs2_busy}, 32'd1);

      // ---------------- reset mid-operation ----------------
      idle_inputs();
      alu_wren = 1'b1; alu_rd = 5'd10; alu_data = 32'h5555;
      ld_valid = 1'b1; ld_rd = 5'd14; ld_data = 32'h1414;
      ld_issue = 1'b1; ld_issue_rd = 5'd20;
      step();
      ld_rd = 5'd15; ld_data = 32'h1515; ld_issue = 1'b0;
      step();
      chk("pre_rst_wren", {31'd0, rd_wren}, 32'd1);
      idle_inputs();
      reset_n = 1'b0;
      #1;
      chk("rst_async_wren", {31'd0, rd_wren}, 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      rs1_addr = 5'd20; rs2_addr = 5'd3;
      step();
      chk("post_rst_busy1", {31'd0, rs1_busy}, 32'd0);
      idle_inputs();
      step();

      // ---------------- randomized traffic ----------------
      for (int k = 0; k < 400; k++) begin
         alu_wren = 1'($urandom_range(0, 1));
         r        = 5'($urandom_range(0, 31));
         alu_rd   = m_sb[r] ? 5'd0 : r;
         alu_data = $urandom();
         ld_issue = ($urandom_range(0, 3) == 0);
         ld_issue_rd = 5'($urandom_range(0, 31));
         if (ld_issue && ld_issue_rd != 0) pend.push_back(ld_issue_rd);
         if (!ld_valid || m_accepted) begin
            ld_valid = ($urandom_range(0, 2) == 0);
            if (ld_valid) begin
               ld_rd   = (pend.size() > 0) ? pend.pop_front() : 5'($urandom_range(0, 31));
               ld_data = $urandom();
            end
         end
         rs1_addr = 5'($urandom_range(0, 31));
         rs2_addr = 5'($urandom_range(0, 31));
`ifdef RF_WB_FWD_EN
         rs1_rdata = $urandom();
         rs2_rdata = $urandom();
`endif
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
